// File: rtl/perceptron_layer_if.sv
// perceptron_layer_if: control, weight-write and result signals of perceptron_layer.
// The w_addr width grows when PERCEPTRON_BIAS_EN adds the bias registers.
interface perceptron_layer_if #(
    parameter int N_INPUTS  = 9,
    parameter int N_NEURONS = 2,
    parameter int DATA_W    = 16,
    parameter int WEIGHT_W  = 16,
    parameter int ACC_W     = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1,
`ifdef PERCEPTRON_BIAS_EN
    parameter int AW        = $clog2(N_NEURONS * (N_INPUTS + 1))
`else
    parameter int AW        = $clog2(N_NEURONS * N_INPUTS)
`endif
);
    logic                          start;
    logic [N_INPUTS*DATA_W-1:0]    in_flat;
    logic                          w_we;
    logic [AW-1:0]                 w_addr;
    logic [WEIGHT_W-1:0]           w_data;
    logic                          busy;
    logic                          done;
    logic [N_NEURONS*ACC_W-1:0]    acc_flat;
    logic [N_NEURONS-1:0]          class_out;

    modport master (
        output start, in_flat, w_we, w_addr, w_data,
        input  busy, done, acc_flat, class_out
    );

    modport slave (
        input  start, in_flat, w_we, w_addr, w_data,
        output busy, done, acc_flat, class_out
    );
endinterface

// File: rtl/perceptron_layer.sv
// perceptron_layer: one-MAC-per-cycle layer of step-activated perceptrons.
// Define PERCEPTRON_BIAS_EN to add per-neuron bias registers addressed after the weights.
module perceptron_layer #(
    parameter int N_INPUTS  = 9,
    parameter int N_NEURONS = 2,
    parameter int DATA_W    = 16,
    parameter int WEIGHT_W  = 16,
    parameter int ACC_W     = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1
) (
    input logic               clk,
    input logic               rst_n,
    perceptron_layer_if.slave bus
);
    localparam int NW = N_NEURONS * N_INPUTS;
`ifdef PERCEPTRON_BIAS_EN
    localparam int NA = N_NEURONS * (N_INPUTS + 1);
`else
    localparam int NA = NW;
`endif
    localparam int AW = $clog2(NA);
    localparam int PW = DATA_W + WEIGHT_W;
    localparam int IW = $clog2(N_INPUTS);
    localparam int JW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_NEURONS - 1);
    localparam logic [AW:0]   NW_A   = (AW+1)'(NW);

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              i_q, i_d;
    logic [JW-1:0]              j_q, j_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   snap_q [N_INPUTS];
    logic signed [DATA_W-1:0]   snap_d [N_INPUTS];
    logic signed [WEIGHT_W-1:0] weight_q [NW];
    logic signed [WEIGHT_W-1:0] weight_d [NW];
    logic signed [ACC_W-1:0]    res_q [N_NEURONS];
    logic signed [ACC_W-1:0]    res_d [N_NEURONS];
    logic [N_NEURONS-1:0]       cls_q, cls_d;
    logic [AW-1:0]              widx;
    logic signed [PW-1:0]       prod;
    logic signed [ACC_W-1:0]    sum, acc_init;

    always_comb begin
        weight_d = weight_q;
        if (state_q == IDLE && bus.w_we && {1'b0, bus.w_addr} < NW_A)
            weight_d[bus.w_addr] = bus.w_data;
    end

`ifdef PERCEPTRON_BIAS_EN
    localparam logic [AW:0] NA_A = (AW+1)'(NA);
    logic signed [WEIGHT_W-1:0] bias_q [N_NEURONS];
    logic signed [WEIGHT_W-1:0] bias_d [N_NEURONS];
    logic [AW-1:0]              baddr;
    logic [JW-1:0]              jn;

    function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [WEIGHT_W-1:0] v);
        return ACC_W'(v);
    endfunction

    assign baddr = bus.w_addr - AW'(NW);
    assign jn    = j_q + 1'b1;

    always_comb begin
        bias_d = bias_q;
        if (state_q == IDLE && bus.w_we && {1'b0, bus.w_addr} >= NW_A && {1'b0, bus.w_addr} < NA_A)
            bias_d[baddr] = bus.w_data;
    end

    // bias_d lets a bias written alongside start seed the very first neuron
    assign acc_init = state_q == IDLE ? sext_w(bias_d[0]) :
                      (j_q == J_LAST ? '0 : sext_w(bias_q[jn]));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < N_NEURONS; k++) bias_q[k] <= '0;
        else bias_q <= bias_d;
`else
    assign acc_init = '0;
`endif

    assign widx = AW'(int'(j_q) * N_INPUTS + int'(i_q));
    assign prod = PW'(snap_q[i_q]) * PW'(weight_q[widx]);
    assign sum  = acc_q + ACC_W'(prod);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        res_d   = res_q;
        cls_d   = cls_q;
        case (state_q)
            IDLE: if (bus.start) begin
                for (int k = 0; k < N_INPUTS; k++) snap_d[k] = bus.in_flat[k*DATA_W +: DATA_W];
                acc_d   = acc_init;
                i_d     = '0;
                j_d     = '0;
                state_d = MAC;
            end
            MAC: if (i_q == I_LAST) begin
                res_d[j_q] = sum;
                cls_d[j_q] = sum > 0;
                acc_d      = acc_init;
                i_d        = '0;
                j_d        = j_q + 1'b1;
                state_d    = j_q == J_LAST ? DONE : MAC;
            end else begin
                acc_d = sum;
                i_d   = i_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            cls_q   <= '0;
            for (int k = 0; k < N_INPUTS; k++) snap_q[k] <= '0;
            for (int k = 0; k < NW; k++) weight_q[k] <= '0;
            for (int k = 0; k < N_NEURONS; k++) res_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            cls_q    <= cls_d;
            snap_q   <= snap_d;
            weight_q <= weight_d;
            res_q    <= res_d;
        end

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.class_out = cls_q;
    for (genvar g = 0; g < N_NEURONS; g++) begin : g_out
        assign bus.acc_flat[g*ACC_W +: ACC_W] = res_q[g];
    end
endmodule

// File: doc/perceptron_layer.md
PERCEPTRON_LAYER -- requirements
Module: perceptron_layer

Interface
REQ-001 N_INPUTS, 9, number of inputs per neuron (>=2).
REQ-002 N_NEURONS, 2, number of neurons in the layer (>=1).
REQ-003 DATA_W, 16, signed input sample width.
REQ-004 WEIGHT_W, 16, signed weight width.
REQ-005 ACC_W, DATA_W+WEIGHT_W+$clog2(N_INPUTS)+1, signed accumulator and result width.
REQ-006 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock; all state changes on this edge except reset.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle request to evaluate the layer; honoured only in IDLE.
REQ-010 in_flat  in  N_INPUTS*DATA_W  signed inputs; input k occupies bits [k*DATA_W +: DATA_W].
REQ-011 w_we  in  1  weight write strobe.
REQ-012 w_addr  in  $clog2(N_NEURONS*N_INPUTS)  weight index, computed as neuron*N_INPUTS + input.
REQ-013 w_data  in  WEIGHT_W  signed weight value.
REQ-014 busy  out  1  high from the cycle after start is accepted until done.
REQ-015 done  out  1  one-cycle pulse when all results are valid.
REQ-016 acc_flat  out  N_NEURONS*ACC_W  signed per-neuron sums; neuron j occupies bits [j*ACC_W +: ACC_W].
REQ-017 class_out  out  N_NEURONS  step activation per neuron.

Function
REQ-018 States: IDLE, MAC, DONE; all other encodings SHALL return to IDLE.
REQ-019 IDLE with start=1: latch in_flat into an internal snapshot, clear accumulator, set neuron index j=0 and input index i=0, then go to MAC.
REQ-020 MAC: perform one signed product snapshot[i]*weight[j*N_INPUTS+i] per cycle, sign-extend it to ACC_W and add it to the accumulator.
REQ-021 MAC at i=N_INPUTS-1: write acc+product to result[j], set class_out[j]=(acc+product > 0), clear the accumulator, set i=0 and j=j+1.
REQ-022 MAC at i=N_INPUTS-1 with j=N_NEURONS-1: go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-024 Latency: start accepted at edge 0 -> done high during cycle N_INPUTS*N_NEURONS+1.
REQ-025 Sums equal to 0 give class 0; negative sums give class 0.
REQ-026 ACC_W is sized so the accumulator never overflows; no saturation is applied.
REQ-027 start while busy or in DONE is ignored; no queuing.
REQ-028 w_we is honoured only in IDLE; writes while busy or in DONE are dropped, so weights are stable during evaluation.
REQ-029 w_we and start in the same IDLE cycle: the weight write takes effect before the first MAC cycle.
REQ-030 w_addr >= N_NEURONS*N_INPUTS: the write is ignored.
REQ-031 acc_flat and class_out hold their values until overwritten by a later evaluation; changes to in_flat after start do not affect results.

Reset
REQ-032 rst_n=0 at any time, including mid-MAC: state=IDLE, busy=0, done=0, acc_flat=0, class_out=0, accumulator and indices cleared; any evaluation in progress is abandoned.
REQ-033 Weights SHALL reset to 0.
REQ-034 After rst_n deasserts, the first rising edge SHALL accept start.

Configuration
REQ-035 Macro PERCEPTRON_BIAS_EN enables a per-neuron signed bias register file of WEIGHT_W bits, reset to 0.
REQ-036 With PERCEPTRON_BIAS_EN, bias addresses follow the weights: w_addr = N_NEURONS*N_INPUTS + j.
REQ-037 With PERCEPTRON_BIAS_EN, the accumulator for neuron j is initialised to sign-extended bias[j] instead of 0.
REQ-038 With PERCEPTRON_BIAS_EN, the w_addr width grows to $clog2(N_NEURONS*(N_INPUTS+1)).
REQ-039 Without PERCEPTRON_BIAS_EN: no bias storage exists and the accumulator initialises to 0.

Verification
REQ-040 Defaults; inputs 0,0,4,1,300,440,0,0,0; neuron0 weights all +1; neuron1 weights all -1 -> result0=745, result1=-745, class_out=2'b01, done in cycle 19.
REQ-041 Inputs 0,2,11,1,520,0,0,0,0; neuron0 weights all +1 -> result0=534 and class_out[0]=1; neuron1 weights all 0 -> result1=0 and class_out[1]=0.
REQ-042 Second start pulse and a w_we to address 0 issued at cycle 5 of an evaluation -> both ignored; results identical to REQ-040; weight 0 unchanged afterwards.
REQ-043 rst_n pulsed low at cycle 7 of an evaluation -> busy, done, acc_flat and class_out all 0 immediately; a fresh start then reproduces the REQ-040 results.
REQ-044 PERCEPTRON_BIAS_EN defined; REQ-040 stimulus plus bias1=+800 -> result1=55 and class_out=2'b11.
REQ-045 Extreme operands: all inputs -32768 and all weights -32768 -> result = 9*2^30, with no overflow and the correct sign.
